mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbiter and sequencer for the single shared memory port behind the EX/MEM pipeline register. It serves the data access held in EX/MEM (MemRead/MemWrite, ALU result as address, B as store data, storetype) and the instruction fetch from IF. It runs multi-cycle memory handshakes, optionally performs read-modify-write for sub-word stores, and drives a global stall that freezes PC and all pipeline registers until both accesses of the current cycle are served.

## Interface
- MAX_WAIT, 15: cycles a request may wait for mem_ready before the bus error trips (4-bit counter, 1..15).
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low.
- if_req  in  1  fetch request from IF; held while stall.
- if_addr  in  32  fetch address, word aligned.
- if_rdata  out  32  fetched word; holds last value.
- if_done  out  1  fetch served for the current pipeline cycle.
- MemRead, MemWrite  in  1 each  from EX/MEM; both high is treated as MemWrite.
- ALUresult  in  32  data address.
- B  in  32  store data.
- storetype  in  2  00 word, 01 half, 10 byte, 11 treated as word.
- d_rdata  out  32  raw loaded word; holds last value.
- d_done  out  1  data access served for the current pipeline cycle.
- stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- mem_req, mem_we  out  1 each  memory request and write enable.
- mem_addr  out  32  word address: {addr[31:2],2'b00}.
- mem_wdata  out  32  write data.
- mem_be  out  4  byte enables, lane i = bits [8i+7:8i].
- mem_rdata  in  32  read data, valid when mem_ready is high.
- mem_ready  in  1  completes the outstanding request.
- bus_err  out  1  sticky timeout flag.

## Operation
- States: IDLE, DRD, DWR, RMW_RD, RMW_WR, IFETCH, ERR.
- Flags d_served and i_served drive d_done and if_done.
  - Each flag sets on completion of its access.
  - Both flags clear on any clock edge where stall=0 (pipeline advances).
- stall = ((MemRead|MemWrite) & !d_served) | (if_req & !i_served) | (state==ERR).
- IDLE selection, in priority order:
  - Data first (older instruction): MemWrite → DWR, or RMW_RD for a sub-word store when RMW is compiled in. MemRead → DRD.
  - Then fetch → IFETCH.
  - No issue in a cycle where stall=0; the request belongs to the instruction that is leaving.
- Wait states: mem_req is held high; mem_addr, mem_we, mem_wdata and mem_be are held stable.
  - On an edge with mem_ready=1: capture mem_rdata (DRD → d_rdata, IFETCH → if_rdata), set the flag, go to IDLE (RMW_RD → RMW_WR instead).
- Store lanes (off = addr[1:0]; a half-word uses off & 2'b10; little-endian):
  - Word: mem_be=1111, mem_wdata=B.
  - Half: lanes off, off+1.
  - Byte: lane off.
- Watchdog: a counter clears on entry to each wait state and increments each cycle without mem_ready. When it reaches MAX_WAIT → ERR.
- ERR: mem_req=0, bus_err=1, stall=1 until reset.

## Timing
- Reset asserted: every output is 0 (stall, done flags, rdata regs, mem_* regs, bus_err), state=IDLE, counter=0. This takes effect immediately, including mid-transaction; the in-flight request is abandoned.
- All mem_* outputs, the done flags and the rdata outputs are registered. stall is combinational from inputs, flags and state.
- Zero-wait memory (mem_ready in the first mem_req cycle):
  - Single access: cycle 0 request seen, stall=1. Cycle 1 mem_req=1, mem_ready=1. Cycle 2 done=1, stall=0, pipeline advances at the end of cycle 2.
  - Data plus fetch in the same cycle: 2 cycles each, stall released in cycle 4.
  - RMW store: 2 extra cycles.
- Each wait cycle adds 1 cycle.
- mem_req deasserts for at least one cycle between transactions.
- mem_ready while mem_req=0 is ignored.

## Configuration
- MEM_ARB_RMW_EN:
  - Defined: a sub-word store does RMW_RD, then RMW_WR. The read word is merged with the selected B lanes and written with mem_be=1111.
  - Undefined: a sub-word store is a single DWR. The masked mem_be is used and mem_wdata replicates B[7:0] to all lanes (byte) or B[15:0] to both halves (half). RMW_RD and RMW_WR are unreachable.

## Test plan
- Reset with if_req=1: stall=0 and all outputs 0. After release, mem_req=1 at mem_addr=if_addr on the second edge; if_rdata captured; stall low 1 cycle later.
- MemRead at ALUresult=0x1006 with if_req in the same cycle, zero-wait memory: data access first (mem_addr=0x1004), then fetch; stall high 4 cycles; d_rdata=mem_rdata of the first transaction.
- Byte store B=0x000000AB at 0x2003, RMW off: mem_be=1000, mem_wdata=0xABABABAB, mem_we=1. RMW on with memory word 0x11223344: read, then write 0xAB223344 with be=1111.
- Half store B=0xBEEF at 0x3001 (RMW off): lanes 00, be=0011, mem_wdata=0xBEEFBEEF.
- mem_ready held low for 15 cycles: ERR state, bus_err=1, mem_req=0, stall stuck at 1. Asserting reset clears everything.
- Reset asserted mid-DRD wait: mem_req drops immediately, d_done=0, d_rdata=0; no spurious capture on release.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - shared memory port bus between the arbiter (master) and memory (slave)
//
// Signals:
//   mem_req    request strobe, held until mem_ready
//   mem_we     write enable
//   mem_addr   word-aligned address
//   mem_wdata  write data
//   mem_be     byte enables, lane i = bits [8i+7:8i]
//   mem_rdata  read data, valid with mem_ready
//   mem_ready  completes the outstanding request
interface mem_port_arbiter_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - arbiter/sequencer for the single memory port shared by EX/MEM data and IF fetch
//
// Ports:
//   clk, reset                  clock, asynchronous active-low reset
//   if_req, if_addr             fetch request/address from IF
//   if_rdata, if_done           fetched word (held), fetch served this pipeline cycle
//   MemRead, MemWrite           data access from EX/MEM (both high = write)
//   ALUresult, B, storetype     data address, store data, 00 word / 01 half / 10 byte / 11 word
//   d_rdata, d_done             loaded word (held), data access served this pipeline cycle
//   stall                       freezes PC and all pipeline registers
//   bus_err                     sticky watchdog timeout
//   mem                         memory bus (master side)
// Build option: MEM_ARB_RMW_EN selects read-modify-write for sub-word stores.
module mem_port_arbiter #(
    parameter int MAX_WAIT = 15
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     if_req,
    input  logic [31:0]              if_addr,
    output logic [31:0]              if_rdata,
    output logic                     if_done,
    input  logic                     MemRead,
    input  logic                     MemWrite,
    input  logic [31:0]              ALUresult,
    input  logic [31:0]              B,
    input  logic [1:0]               storetype,
    output logic [31:0]              d_rdata,
    output logic                     d_done,
    output logic                     stall,
    output logic                     bus_err,
    mem_port_arbiter_if.master       mem
);

`ifdef MEM_ARB_RMW_EN
    localparam bit RMW_EN = 1'b1;
`else
    localparam bit RMW_EN = 1'b0;
`endif

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DRD    = 3'd1;
    localparam logic [2:0] ST_DWR    = 3'd2;
    localparam logic [2:0] ST_RMW_RD = 3'd3;
    localparam logic [2:0] ST_RMW_WR = 3'd4;
    localparam logic [2:0] ST_IFETCH = 3'd5;
    localparam logic [2:0] ST_ERR    = 3'd6;

    logic [2:0]  state;
    logic [3:0]  wait_cnt;
    logic        d_served;
    logic        i_served;
    logic        data_pend;
    logic        fetch_pend;
    logic        sub_word;
    logic [3:0]  lane_be;
    logic [31:0] lane_data;
    logic [31:0] merged;

    assign data_pend  = (MemRead | MemWrite) & ~d_served;
    assign fetch_pend = if_req & ~i_served;
    // Gated by reset so every output reads 0 while reset is held.
    assign stall      = reset & (data_pend | fetch_pend | (state == ST_ERR));
    assign d_done     = d_served;
    assign if_done    = i_served;
    assign sub_word   = (storetype == 2'b01) || (storetype == 2'b10);

    // Lane selection for the store; the data is replicated so any lane pick is correct.
    always_comb begin
        case (storetype)
            2'b01: begin
                lane_be   = ALUresult[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{B[15:0]}};
            end
            2'b10: begin
                lane_be   = 4'b0001 << ALUresult[1:0];
                lane_data = {4{B[7:0]}};
            end
            default: begin
                lane_be   = 4'b1111;
                lane_data = B;
            end
        endcase
    end

    always_comb begin
        merged = mem.mem_rdata;
        for (int i = 0; i < 4; i++) begin
            if (lane_be[i]) merged[8*i +: 8] = lane_data[8*i +: 8];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            wait_cnt      <= 4'd0;
            d_served      <= 1'b0;
            i_served      <= 1'b0;
            d_rdata       <= 32'd0;
            if_rdata      <= 32'd0;
            bus_err       <= 1'b0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= 32'd0;
            mem.mem_wdata <= 32'd0;
            mem.mem_be    <= 4'd0;
        end else begin
            // Pipeline advances on this edge: the next instruction starts unserved.
            if (!stall) begin
                d_served <= 1'b0;
                i_served <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    // Pending requests imply stall=1, so the leaving instruction never issues.
                    if (data_pend) begin
                        mem.mem_req  <= 1'b1;
                        mem.mem_addr <= {ALUresult[31:2], 2'b00};
                        wait_cnt     <= 4'd0;
                        if (MemWrite && RMW_EN && sub_word) begin
                            state      <= ST_RMW_RD;
                            mem.mem_we <= 1'b0;
                            mem.mem_be <= 4'b1111;
                        end else if (MemWrite) begin
                            state         <= ST_DWR;
                            mem.mem_we    <= 1'b1;
                            mem.mem_be    <= lane_be;
                            mem.mem_wdata <= lane_data;
                        end else begin
                            state      <= ST_DRD;
                            mem.mem_we <= 1'b0;
                            mem.mem_be <= 4'b1111;
                        end
                    end else if (fetch_pend) begin
                        state        <= ST_IFETCH;
                        mem.mem_req  <= 1'b1;
                        mem.mem_we   <= 1'b0;
                        mem.mem_be   <= 4'b1111;
                        mem.mem_addr <= if_addr & 32'hFFFF_FFFC;
                        wait_cnt     <= 4'd0;
                    end
                end
                ST_DRD, ST_DWR, ST_RMW_RD, ST_RMW_WR, ST_IFETCH: begin
                    if (!mem.mem_req) begin
                        // Only RMW_WR arrives with mem_req low: the one-cycle gap after the read.
                        mem.mem_req <= 1'b1;
                        wait_cnt    <= 4'd0;
                    end else if (mem.mem_ready) begin
                        mem.mem_req <= 1'b0;
                        case (state)
                            ST_DRD: begin
                                d_rdata  <= mem.mem_rdata;
                                d_served <= 1'b1;
                                state    <= ST_IDLE;
                            end
                            ST_RMW_RD: begin
                                mem.mem_we    <= 1'b1;
                                mem.mem_wdata <= merged;
                                state         <= ST_RMW_WR;
                            end
                            ST_IFETCH: begin
                                if_rdata <= mem.mem_rdata;
                                i_served <= 1'b1;
                                state    <= ST_IDLE;
                            end
                            default: begin
                                d_served <= 1'b1;
                                state    <= ST_IDLE;
                            end
                        endcase
                    end else if (wait_cnt == 4'(MAX_WAIT - 1)) begin
                        mem.mem_req <= 1'b0;
                        bus_err     <= 1'b1;
                        state       <= ST_ERR;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                ST_ERR: state <= ST_ERR;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'd0;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] ALUresult = 32'd0;
    logic [31:0] B = 32'd0;
    logic [1:0]  storetype = 2'b00;
    logic [31:0] d_rdata;
    logic        d_done;
    logic        stall;
    logic        bus_err;

    mem_port_arbiter_if bus ();

    mem_port_arbiter dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .MemRead(MemRead), .MemWrite(MemWrite), .ALUresult(ALUresult), .B(B),
        .storetype(storetype), .d_rdata(d_rdata), .d_done(d_done), .stall(stall),
        .bus_err(bus_err), .mem(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } txn_t;

    txn_t        txn_q[$];
    logic [31:0] d_q[$];
    logic [31:0] i_q[$];
    logic [31:0] resp_q[$];
    logic [31:0] exp_d = 32'd0;
    logic [31:0] exp_i = 32'd0;

    int checks = 0;
    int errors = 0;
    int wait_n = 0;
    bit hang = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push_txn(input logic [31:0] a, input logic w, input logic [3:0] be, input logic [31:0] wd);
        txn_t t;
        t.addr = a; t.we = w; t.be = be; t.wdata = wd;
        txn_q.push_back(t);
    endtask

    task automatic exp_data(input bit is_read, input logic [31:0] v);
        if (is_read) exp_d = v;
        d_q.push_back(exp_d);
    endtask

    task automatic exp_fetch(input logic [31:0] v);
        exp_i = v;
        i_q.push_back(exp_i);
    endtask

    // Memory model: answers after wait_n extra cycles unless hang is set.
    int age = 0;
    initial begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'd0;
        forever begin
            @(negedge clk);
            if (bus.mem_req && !hang && age >= wait_n) begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = (resp_q.size() > 0) ? resp_q.pop_front() : 32'd0;
            end else begin
                bus.mem_ready = 1'b0;
            end
            age = bus.mem_req ? age + 1 : 0;
        end
    end

    // Monitor: compares every new bus transaction and every done pulse against the queues.
    logic prev_req = 1'b0, prev_dd = 1'b0, prev_id = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (bus.mem_req && !prev_req) begin
                if (txn_q.size() == 0) begin
                    chk("unexpected_txn", bus.mem_addr, 32'hFFFF_FFFF);
                end else begin
                    txn_t t;
                    t = txn_q.pop_front();
                    chk("txn_addr", bus.mem_addr, t.addr);
                    chk("txn_we", {31'd0, bus.mem_we}, {31'd0, t.we});
                    chk("txn_be", {28'd0, bus.mem_be}, {28'd0, t.be});
                    if (t.we) chk("txn_wdata", bus.mem_wdata, t.wdata);
                end
            end
            if (d_done && !prev_dd) begin
                if (d_q.size() == 0) chk("unexpected_d_done", d_rdata, 32'hFFFF_FFFF);
                else chk("d_rdata", d_rdata, d_q.pop_front());
            end
            if (if_done && !prev_id) begin
                if (i_q.size() == 0) chk("unexpected_if_done", if_rdata, 32'hFFFF_FFFF);
                else chk("if_rdata", if_rdata, i_q.pop_front());
            end
            prev_req = bus.mem_req;
            prev_dd  = d_done;
            prev_id  = if_done;
        end
    end

    // Counts stalled cycles of the current pipeline cycle, then lets it advance.
    task automatic run_cycle(input string name, input int exp_n);
        int n = 0;
        forever begin
            @(negedge clk);
            if (!stall) break;
            n++;
            if (n > 60) break;
        end
        chk(name, n, exp_n);
        @(posedge clk); #1;
        MemRead = 1'b0; MemWrite = 1'b0; if_req = 1'b0;
    endtask

    task automatic store(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] st, input logic [3:0] be, input logic [31:0] wd,
                         input logic [31:0] old_word, input logic [31:0] merged_word);
        ALUresult = a; B = b; storetype = st; MemWrite = 1'b1;
`ifdef MEM_ARB_RMW_EN
        if (st == 2'b01 || st == 2'b10) begin
            resp_q.push_back(old_word);
            push_txn({a[31:2], 2'b00}, 1'b0, 4'b1111, 32'd0);
            push_txn({a[31:2], 2'b00}, 1'b1, 4'b1111, merged_word);
            exp_data(1'b0, 32'd0);
            run_cycle(name, 4);
            return;
        end
`endif
        push_txn({a[31:2], 2'b00}, 1'b1, be, wd);
        exp_data(1'b0, 32'd0);
        run_cycle(name, 2);
        if (old_word == merged_word) chk("unused_store_args", 32'd0, 32'd0 + 0);
    endtask

    initial begin
        // Reset held with a fetch pending: nothing may move.
        if_req = 1'b1; if_addr = 32'h0000_0100;
        @(negedge clk); @(negedge clk);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_flags", {28'd0, if_done, d_done, bus_err, bus.mem_req}, 32'd0);
        chk("rst_rdata", if_rdata | d_rdata, 32'd0);
        chk("rst_bus", bus.mem_addr | bus.mem_wdata | {27'd0, bus.mem_be, bus.mem_we}, 32'd0);
        resp_q.push_back(32'hCAFE_0001);
        push_txn(32'h0000_0100, 1'b0, 4'b1111, 32'd0);
        exp_fetch(32'hCAFE_0001);
        @(posedge clk); #1;
        reset = 1'b1;
        run_cycle("fetch_after_reset_stall", 2);

        // Data read plus fetch in the same cycle: data first, stall for 4 cycles.
        MemRead = 1'b1; ALUresult = 32'h0000_1006; if_req = 1'b1; if_addr = 32'h0000_0104;
        resp_q.push_back(32'h1111_0000); resp_q.push_back(32'h2222_0000);
        push_txn(32'h0000_1004, 1'b0, 4'b1111, 32'd0);
        push_txn(32'h0000_0104, 1'b0, 4'b1111, 32'd0);
        exp_data(1'b1, 32'h1111_0000);
        exp_fetch(32'h2222_0000);
        run_cycle("read_fetch_stall", 4);

        // Sub-word and word stores.
        store("byte_store_stall", 32'h0000_2003, 32'h0000_00AB, 2'b10, 4'b1000, 32'hABAB_ABAB,
              32'h1122_3344, 32'hAB22_3344);
        store("half_lo_store_stall", 32'h0000_3001, 32'h0000_BEEF, 2'b01, 4'b0011, 32'hBEEF_BEEF,
              32'h5566_7788, 32'h5566_BEEF);
        store("half_hi_store_stall", 32'h0000_3002, 32'h0000_1234, 2'b01, 4'b1100, 32'h1234_1234,
              32'h5566_7788, 32'h1234_7788);
        store("byte0_store_stall", 32'h0000_2004, 32'h0000_0077, 2'b10, 4'b0001, 32'h7777_7777,
              32'hAAAA_AAAA, 32'hAAAA_AA77);
        // MemRead and MemWrite together with storetype 11: a word write.
        MemRead = 1'b1;
        store("word_store_stall", 32'h0000_4000, 32'hDEAD_BEEF, 2'b11, 4'b1111, 32'hDEAD_BEEF,
              32'd0, 32'd0);

        // Three wait cycles add three stall cycles.
        wait_n = 3;
        MemRead = 1'b1; ALUresult = 32'h0000_5000;
        resp_q.push_back(32'h5A5A_0003);
        push_txn(32'h0000_5000, 1'b0, 4'b1111, 32'd0);
        exp_data(1'b1, 32'h5A5A_0003);
        run_cycle("wait3_stall", 5);
        wait_n = 0;

        // Reset in the middle of a read wait: request abandoned at once.
        hang = 1'b1;
        MemRead = 1'b1; ALUresult = 32'h0000_6000;
        push_txn(32'h0000_6000, 1'b0, 4'b1111, 32'd0);
        repeat (4) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("midrst_req", {31'd0, bus.mem_req}, 32'd0);
        chk("midrst_d_rdata", d_rdata, 32'd0);
        chk("midrst_d_done", {31'd0, d_done}, 32'd0);
        exp_d = 32'd0; exp_i = 32'd0;
        MemRead = 1'b0;
        hang = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_rst_no_capture", d_rdata | {31'd0, d_done | bus.mem_req}, 32'd0);

        // Watchdog: memory never answers.
        hang = 1'b1;
        begin
            int req_cycles = 0;
            @(posedge clk); #1;
            MemRead = 1'b1; ALUresult = 32'h0000_7000;
            push_txn(32'h0000_7000, 1'b0, 4'b1111, 32'd0);
            repeat (25) begin
                @(negedge clk);
                if (bus.mem_req) req_cycles++;
            end
            chk("timeout_req_cycles", req_cycles, 15);
        end
        chk("err_bus_err", {31'd0, bus_err}, 32'd1);
        chk("err_req", {31'd0, bus.mem_req}, 32'd0);
        chk("err_stall", {31'd0, stall}, 32'd1);
        MemRead = 1'b0;
        @(negedge clk);
        chk("err_stall_sticky", {31'd0, stall}, 32'd1);
        reset = 1'b0;
        #1;
        chk("err_cleared", {29'd0, bus_err, stall, bus.mem_req}, 32'd0);
        hang = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(negedge clk);

        chk("txn_q_drained", txn_q.size(), 0);
        chk("d_q_drained", d_q.size(), 0);
        chk("i_q_drained", i_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time bound so the bench always terminates.
    initial begin
        #200000;
        errors++;
        $display("FAIL global_timeout: got running expected finished");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
